mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, length encodings, FSM state encoding and grant-side encoding
// for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LINE_W = 512;
   localparam int LEN_W      = 3;

   localparam logic [LEN_W-1:0] LEN_BYTE = 3'd1;
   localparam logic [LEN_W-1:0] LEN_HALF = 3'd2;
   localparam logic [LEN_W-1:0] LEN_WORD = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BUSY_IF  = 3'd1,
      ST_BUSY_LS  = 3'd2,
      ST_FLUSH_ST = 3'd3,
      ST_GAP      = 3'd4
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } side_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: when both sides request, the side that was not
// granted last wins.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic  req_if_i,
   input  logic  req_ls_i,
   input  side_t last_i,
   output logic  gnt_if_o,
   output logic  gnt_ls_o
);

   always_comb begin
      gnt_if_o = req_if_i && (!req_ls_i || (last_i == GNT_LS));
      gnt_ls_o = req_ls_i && !gnt_if_o;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one instruction-fetch line port and one load/store port onto a
// single memory controller, one outstanding transaction at a time.
//
// Handshake: a requester holds valid and payload stable until its rsp pulse or
// a rollback; the arbiter holds mc_* valid and payload stable until the matching
// done input, which is honoured only in the state that expects it.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_rsp_valid,
   output logic [LINE_W-1:0] if_rsp_line,
   input  logic              ls_req_valid,
   input  logic              ls_req_is_store,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [LEN_W-1:0]  ls_req_len,
   input  logic [DATA_W-1:0] ls_req_data,
   output logic              ls_rsp_valid,
   output logic [DATA_W-1:0] ls_rsp_data,
   output logic              mc_if_valid,
   output logic [ADDR_W-1:0] mc_if_addr,
   output logic              mc_ls_valid,
   output logic              mc_ls_is_store,
   output logic [ADDR_W-1:0] mc_ls_addr,
   output logic [LEN_W-1:0]  mc_ls_len,
   output logic [DATA_W-1:0] mc_ls_data,
   input  logic              mc_line_valid,
   input  logic [LINE_W-1:0] mc_line,
   input  logic              mc_ls_done,
   input  logic [DATA_W-1:0] mc_ls_rdata,
   output state_t            dbg_state_o
);

   state_t            state_q, state_d;
   side_t             last_q, last_d;
   logic              mc_if_valid_q, mc_if_valid_d;
   logic [ADDR_W-1:0] mc_if_addr_q, mc_if_addr_d;
   logic              mc_ls_valid_q, mc_ls_valid_d;
   logic              mc_ls_is_store_q, mc_ls_is_store_d;
   logic [ADDR_W-1:0] mc_ls_addr_q, mc_ls_addr_d;
   logic [LEN_W-1:0]  mc_ls_len_q, mc_ls_len_d;
   logic [DATA_W-1:0] mc_ls_data_q, mc_ls_data_d;
   logic              gnt_if, gnt_ls;
   logic              rsp_en;
   logic              if_pulse, ls_pulse;

   rr_pick2 u_pick (
      .req_if_i (if_req_valid),
      .req_ls_i (ls_req_valid),
      .last_i   (last_q),
      .gnt_if_o (gnt_if),
      .gnt_ls_o (gnt_ls)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         last_q           <= GNT_LS;
         mc_if_valid_q    <= 1'b0;
         mc_if_addr_q     <= '0;
         mc_ls_valid_q    <= 1'b0;
         mc_ls_is_store_q <= 1'b0;
         mc_ls_addr_q     <= '0;
         mc_ls_len_q      <= '0;
         mc_ls_data_q     <= '0;
      end else if (rdy) begin
         state_q          <= state_d;
         last_q           <= last_d;
         mc_if_valid_q    <= mc_if_valid_d;
         mc_if_addr_q     <= mc_if_addr_d;
         mc_ls_valid_q    <= mc_ls_valid_d;
         mc_ls_is_store_q <= mc_ls_is_store_d;
         mc_ls_addr_q     <= mc_ls_addr_d;
         mc_ls_len_q      <= mc_ls_len_d;
         mc_ls_data_q     <= mc_ls_data_d;
      end
   end

   // Response pulses are combinational off the done input, so they are masked
   // whenever the registers would not advance this cycle.
   assign rsp_en = rdy && !rst;

   always_comb begin
      state_d          = state_q;
      last_d           = last_q;
      mc_if_valid_d    = mc_if_valid_q;
      mc_if_addr_d     = mc_if_addr_q;
      mc_ls_valid_d    = mc_ls_valid_q;
      mc_ls_is_store_d = mc_ls_is_store_q;
      mc_ls_addr_d     = mc_ls_addr_q;
      mc_ls_len_d      = mc_ls_len_q;
      mc_ls_data_d     = mc_ls_data_q;
      if_pulse         = 1'b0;
      ls_pulse         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rollback && gnt_if) begin
               state_d       = ST_BUSY_IF;
               last_d        = GNT_IF;
               mc_if_valid_d = 1'b1;
               mc_if_addr_d  = if_req_addr;
            end else if (!rollback && gnt_ls) begin
               state_d          = ST_BUSY_LS;
               last_d           = GNT_LS;
               mc_ls_valid_d    = 1'b1;
               mc_ls_is_store_d = ls_req_is_store;
               mc_ls_addr_d     = ls_req_addr;
               mc_ls_len_d      = ls_req_len;
               mc_ls_data_d     = ls_req_data;
            end
         end
         ST_BUSY_IF: begin
            if (mc_line_valid || rollback) begin
               if_pulse      = mc_line_valid;
               mc_if_valid_d = 1'b0;
               state_d       = ST_GAP;
            end
         end
         ST_BUSY_LS: begin
            if (mc_ls_done) begin
               ls_pulse      = 1'b1;
               mc_ls_valid_d = 1'b0;
               state_d       = ST_GAP;
            end else if (rollback && mc_ls_is_store_q) begin
               // A store already on the bus must complete; only its response is dropped.
               state_d = ST_FLUSH_ST;
            end else if (rollback) begin
               mc_ls_valid_d = 1'b0;
               state_d       = ST_GAP;
            end
         end
         ST_FLUSH_ST: begin
            if (mc_ls_done) begin
               mc_ls_valid_d = 1'b0;
               state_d       = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign if_rsp_valid   = if_pulse && rsp_en;
   assign if_rsp_line    = if_rsp_valid ? mc_line : '0;
   assign ls_rsp_valid   = ls_pulse && rsp_en;
   assign ls_rsp_data    = (ls_rsp_valid && !mc_ls_is_store_q) ? mc_ls_rdata : '0;
   assign mc_if_valid    = mc_if_valid_q;
   assign mc_if_addr     = mc_if_addr_q;
   assign mc_ls_valid    = mc_ls_valid_q;
   assign mc_ls_is_store = mc_ls_is_store_q;
   assign mc_ls_addr     = mc_ls_addr_q;
   assign mc_ls_len      = mc_ls_len_q;
   assign mc_ls_data     = mc_ls_data_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model tracks which side
// owns the controller and is compared against the DUT on every negedge.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 512;

   logic          clk = 1'b0;
   logic          rst, rdy, rollback;
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_rsp_valid;
   logic [LW-1:0] if_rsp_line;
   logic          ls_req_valid, ls_req_is_store;
   logic [AW-1:0] ls_req_addr;
   logic [2:0]    ls_req_len;
   logic [DW-1:0] ls_req_data;
   logic          ls_rsp_valid;
   logic [DW-1:0] ls_rsp_data;
   logic          mc_if_valid;
   logic [AW-1:0] mc_if_addr;
   logic          mc_ls_valid, mc_ls_is_store;
   logic [AW-1:0] mc_ls_addr;
   logic [2:0]    mc_ls_len;
   logic [DW-1:0] mc_ls_data;
   logic          mc_line_valid;
   logic [LW-1:0] mc_line;
   logic          mc_ls_done;
   logic [DW-1:0] mc_ls_rdata;
   state_t        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_line(if_rsp_line),
      .ls_req_valid(ls_req_valid), .ls_req_is_store(ls_req_is_store),
      .ls_req_addr(ls_req_addr), .ls_req_len(ls_req_len), .ls_req_data(ls_req_data),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
      .mc_if_valid(mc_if_valid), .mc_if_addr(mc_if_addr),
      .mc_ls_valid(mc_ls_valid), .mc_ls_is_store(mc_ls_is_store),
      .mc_ls_addr(mc_ls_addr), .mc_ls_len(mc_ls_len), .mc_ls_data(mc_ls_data),
      .mc_line_valid(mc_line_valid), .mc_line(mc_line),
      .mc_ls_done(mc_ls_done), .mc_ls_rdata(mc_ls_rdata),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // owner: 0 = controller free, 1 = fetch in flight, 2 = load/store in flight
   int            m_owner   = 0;
   bit            m_gap     = 0;
   bit            m_flush   = 0;
   bit            m_last_ls = 1;
   bit            m_started = 0;
   logic [AW-1:0] m_if_addr;
   logic          m_ls_store;
   logic [AW-1:0] m_ls_addr;
   logic [2:0]    m_ls_len;
   logic [DW-1:0] m_ls_data;

   always @(posedge clk) begin
      if (rst) begin
         m_started = 1; m_owner = 0; m_gap = 0; m_flush = 0; m_last_ls = 1;
         m_if_addr = '0; m_ls_store = 1'b0; m_ls_addr = '0; m_ls_len = '0; m_ls_data = '0;
      end else if (rdy) begin
         if (m_gap) begin
            m_gap = 0;
         end else if (m_owner == 1) begin
            if (mc_line_valid || rollback) begin m_owner = 0; m_gap = 1; end
         end else if (m_owner == 2) begin
            if (mc_ls_done) begin
               m_owner = 0; m_gap = 1; m_flush = 0;
            end else if (rollback && !m_flush) begin
               if (m_ls_store) m_flush = 1;
               else begin m_owner = 0; m_gap = 1; end
            end
         end else if (!rollback && (if_req_valid || ls_req_valid)) begin
            if (if_req_valid && (!ls_req_valid || m_last_ls)) begin
               m_owner = 1; m_last_ls = 0; m_if_addr = if_req_addr;
            end else begin
               m_owner = 2; m_last_ls = 1;
               m_ls_store = ls_req_is_store; m_ls_addr = ls_req_addr;
               m_ls_len = ls_req_len; m_ls_data = ls_req_data;
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic e_if, e_ls;
      if (m_started) begin
         e_if = rdy && !rst && (m_owner == 1) && mc_line_valid;
         e_ls = rdy && !rst && (m_owner == 2) && !m_flush && mc_ls_done;
         chk("mc_if_valid", mc_if_valid, m_owner == 1);
         chk("mc_ls_valid", mc_ls_valid, m_owner == 2);
         chk("mc_if_addr", mc_if_addr, m_if_addr);
         chk("mc_ls_is_store", mc_ls_is_store, m_ls_store);
         chk("mc_ls_addr", mc_ls_addr, m_ls_addr);
         chk("mc_ls_len", mc_ls_len, m_ls_len);
         chk("mc_ls_data", mc_ls_data, m_ls_data);
         chk("if_rsp_valid", if_rsp_valid, e_if);
         chk("if_rsp_line", if_rsp_line, e_if ? mc_line : '0);
         chk("ls_rsp_valid", ls_rsp_valid, e_ls);
         chk("ls_rsp_data", ls_rsp_data, (e_ls && !m_ls_store) ? mc_ls_rdata : '0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      rollback = 0; if_req_valid = 0; if_req_addr = '0;
      ls_req_valid = 0; ls_req_is_store = 0; ls_req_addr = '0; ls_req_len = '0; ls_req_data = '0;
      mc_line_valid = 0; mc_line = '0; mc_ls_done = 0; mc_ls_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rdy = 1; rst = 1;
      tick(); tick();
      rst = 0;
   endtask

   task automatic ls_req(input logic st, input logic [AW-1:0] a, input logic [2:0] len,
                         input logic [DW-1:0] d);
      ls_req_valid = 1; ls_req_is_store = st; ls_req_addr = a; ls_req_len = len; ls_req_data = d;
   endtask

   // ---------------- directed stimulus ----------------
   logic [LW-1:0] line_pat;

   initial begin
      line_pat = {16{32'hCAFE_F00D}};
      clear_inputs();
      rdy = 1; rst = 1;
      tick(); tick();
      settle();
      chk("reset_mc_if_valid", mc_if_valid, 1'b0);
      chk("reset_mc_ls_valid", mc_ls_valid, 1'b0);
      chk("reset_state", dbg_state, ST_IDLE);
      rst = 0;

      // IF only
      if_req_valid = 1; if_req_addr = 32'h1000;
      tick(); settle();
      chk("if_grant_valid", mc_if_valid, 1'b1);
      chk("if_grant_addr", mc_if_addr, 32'h1000);
      tick();
      mc_line_valid = 1; mc_line = line_pat;
      settle();
      chk("if_rsp_pulse", if_rsp_valid, 1'b1);
      chk("if_rsp_line", if_rsp_line, line_pat);
      tick();
      mc_line_valid = 0; if_req_valid = 0;
      settle();
      chk("if_gap_valid", mc_if_valid, 1'b0);
      tick(); settle();
      chk("if_back_idle", dbg_state, ST_IDLE);

      // both pending: IF first, then LS beats a fresh IF request
      do_reset();
      if_req_valid = 1; if_req_addr = 32'h2000;
      ls_req(1'b0, 32'h20, LEN_WORD, 32'h0);
      tick(); settle();
      chk("rr_first_if", mc_if_valid, 1'b1);
      chk("rr_first_not_ls", mc_ls_valid, 1'b0);
      tick();
      mc_line_valid = 1; mc_line = line_pat;
      tick();
      mc_line_valid = 0; if_req_addr = 32'h3000;
      tick();
      tick(); settle();
      chk("rr_second_ls", mc_ls_valid, 1'b1);
      chk("rr_second_not_if", mc_if_valid, 1'b0);
      chk("rr_ls_addr", mc_ls_addr, 32'h20);
      mc_ls_done = 1; mc_ls_rdata = 32'h1234_5678;
      settle();
      chk("ls_rsp_pulse", ls_rsp_valid, 1'b1);
      chk("ls_rsp_data", ls_rsp_data, 32'h1234_5678);
      tick();
      mc_ls_done = 0; ls_req_valid = 0;
      tick();
      tick(); settle();
      chk("rr_third_if", mc_if_valid, 1'b1);
      chk("rr_third_addr", mc_if_addr, 32'h3000);
      tick();
      mc_line_valid = 1;
      tick();
      mc_line_valid = 0; if_req_valid = 0;
      tick(); tick();

      // store with rollback mid-flight
      do_reset();
      ls_req(1'b1, 32'h30, LEN_WORD, 32'hDEAD_BEEF);
      tick(); settle();
      chk("st_valid", mc_ls_valid, 1'b1);
      chk("st_is_store", mc_ls_is_store, 1'b1);
      chk("st_data", mc_ls_data, 32'hDEAD_BEEF);
      tick();
      rollback = 1;
      tick();
      rollback = 0; ls_req_valid = 0;
      settle();
      chk("st_flush_held", mc_ls_valid, 1'b1);
      tick(); tick(); settle();
      chk("st_flush_still", mc_ls_valid, 1'b1);
      mc_ls_done = 1; mc_ls_rdata = 32'h5555_AAAA;
      settle();
      chk("st_flush_no_rsp", ls_rsp_valid, 1'b0);
      tick();
      mc_ls_done = 0;
      settle();
      chk("st_flush_drop", mc_ls_valid, 1'b0);
      tick(); settle();
      chk("st_flush_idle", dbg_state, ST_IDLE);

      // load with rollback, then stray done
      do_reset();
      ls_req(1'b0, 32'h40, LEN_HALF, 32'h0);
      tick(); settle();
      chk("ld_valid", mc_ls_valid, 1'b1);
      rollback = 1;
      tick();
      rollback = 0; ls_req_valid = 0;
      settle();
      chk("ld_rb_drop", mc_ls_valid, 1'b0);
      mc_ls_done = 1; mc_ls_rdata = 32'h0BAD_0BAD;
      settle();
      chk("ld_stray_gap", ls_rsp_valid, 1'b0);
      tick(); settle();
      chk("ld_stray_idle", ls_rsp_valid, 1'b0);
      tick();
      mc_ls_done = 0;
      settle();
      chk("ld_idle", dbg_state, ST_IDLE);

      // rdy low for 5 cycles in BUSY_IF
      do_reset();
      if_req_valid = 1; if_req_addr = 32'h5000;
      tick(); settle();
      chk("frz_grant", mc_if_valid, 1'b1);
      rdy = 0; mc_line_valid = 1; mc_line = line_pat;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("frz_no_rsp", if_rsp_valid, 1'b0);
         chk("frz_valid", mc_if_valid, 1'b1);
         chk("frz_addr", mc_if_addr, 32'h5000);
         tick();
      end
      rdy = 1;
      settle();
      chk("frz_resume_rsp", if_rsp_valid, 1'b1);
      tick();
      mc_line_valid = 0; if_req_valid = 0;
      settle();
      chk("frz_resume_drop", mc_if_valid, 1'b0);
      tick(); tick();

      // rollback coincident with done: done wins
      do_reset();
      if_req_valid = 1; if_req_addr = 32'h6000;
      tick();
      rollback = 1; mc_line_valid = 1; mc_line = line_pat;
      settle();
      chk("rb_done_rsp", if_rsp_valid, 1'b1);
      tick();
      rollback = 0; mc_line_valid = 0; if_req_valid = 0;
      tick(); tick();

      // reset mid BUSY_LS
      do_reset();
      ls_req(1'b0, 32'h60, LEN_BYTE, 32'h0);
      tick(); settle();
      chk("rst_ls_valid", mc_ls_valid, 1'b1);
      rst = 1; mc_ls_done = 1; mc_ls_rdata = 32'h7777_7777;
      settle();
      chk("rst_no_rsp", ls_rsp_valid, 1'b0);
      tick(); settle();
      chk("rst_drop_valid", mc_ls_valid, 1'b0);
      chk("rst_addr_zero", mc_ls_addr, 32'h0);
      chk("rst_idle", dbg_state, ST_IDLE);
      rst = 0; mc_ls_done = 0; ls_req_valid = 0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
